// File: rtl/mult_div_secuencial_pkg.sv
// ============================================================================
// Module  : mult_div_secuencial_pkg
// Brief   : Shared state encodings, opcodes and default width for the
//           sequential multiplier/divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_secuencial_pkg;

    localparam int   ANCHO_DEF = 16;

    localparam logic OP_MULT   = 1'b0;
    localparam logic OP_DIV    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_div_paso.sv
// ============================================================================
// Module  : mult_div_paso
// Brief   : One combinational iteration: shift-add (multiply) or restoring
//           trial-subtract (divide) on a 2N+1 bit accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_paso
    import mult_div_secuencial_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic [2*ANCHO:0]   acc_i,
    input  logic [ANCHO-1:0]   operand_i,
    input  logic               op_i,
    output logic [2*ANCHO:0]   acc_o,
    output logic               qbit_o
);

    logic [ANCHO:0]   sum;
    logic [2*ANCHO:0] sh;
    logic [ANCHO:0]   trial;

    always_comb begin
        sum    = {1'b0, acc_i[2*ANCHO-1:ANCHO]} + {1'b0, operand_i};
        sh     = {acc_i[2*ANCHO-1:0], 1'b0};
        trial  = sh[2*ANCHO:ANCHO] - {1'b0, operand_i};
        acc_o  = acc_i;
        qbit_o = 1'b0;
        if (op_i == OP_DIV) begin
            // Bit 0 is left clear; the caller inserts the quotient bit.
            qbit_o = (sh[2*ANCHO:ANCHO] >= {1'b0, operand_i});
            acc_o  = qbit_o ? {trial, sh[ANCHO-1:0]} : sh;
        end else begin
            acc_o  = acc_i[0] ? {1'b0, sum, acc_i[ANCHO-1:1]}
                              : {1'b0, acc_i[2*ANCHO:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_secuencial.sv
// ============================================================================
// Module  : mult_div_secuencial
// Brief   : Hardwired sequential N x N multiplier / 2N / N divider with a
//           go/done four-phase handshake. Optional err port: MULT_DIV_ERR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_secuencial
    import mult_div_secuencial_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic                 reloj,
    input  logic                 reset,
    input  logic [2*ANCHO-1:0]   ent_32,
    input  logic [ANCHO-1:0]     ent_16,
    input  logic                 go,
    input  logic                 div_mult,
    output logic [2*ANCHO-1:0]   sal_32,
`ifdef MULT_DIV_ERR_EN
    output logic                 err,
`endif
    output logic                 done
);

    localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*ANCHO:0]     acc_q, acc_d;
    logic [ANCHO-1:0]     opnd_q, opnd_d;
    logic                 op_q, op_d;
    logic                 ovf_q, ovf_d;
    logic [2*ANCHO-1:0]   sal_q, sal_d;
    logic                 done_q, done_d;

    logic [2*ANCHO:0]     paso_acc;
    logic                 paso_qbit;
    logic [2*ANCHO:0]     step_acc;

    mult_div_paso #(.ANCHO(ANCHO)) u_paso (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .op_i      (op_q),
        .acc_o     (paso_acc),
        .qbit_o    (paso_qbit)
    );

    assign step_acc = paso_acc | {{(2*ANCHO){1'b0}}, paso_qbit};

    always_ff @(posedge reloj) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= OP_MULT;
            ovf_q   <= 1'b0;
            sal_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
            sal_q   <= sal_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        sal_d   = sal_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    op_d    = div_mult;
                    cnt_d   = CW'(ANCHO - 1);
                    state_d = ST_CALC;
                    if (div_mult == OP_DIV) begin
                        opnd_d = ent_16;
                        acc_d  = {1'b0, ent_32};
                        // A quotient that cannot fit in N bits is flagged up front.
                        ovf_d  = (ent_16 == '0) || (ent_32[2*ANCHO-1:ANCHO] >= ent_16);
                    end else begin
                        opnd_d = ent_32[ANCHO-1:0];
                        acc_d  = {1'b0, {ANCHO{1'b0}}, ent_16};
                        ovf_d  = 1'b0;
                    end
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    sal_d   = ovf_q ? '1 : step_acc[2*ANCHO-1:0];
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                if (!go) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    assign sal_32 = sal_q;
    assign done   = done_q;

`ifdef MULT_DIV_ERR_EN
    logic err_q;

    always_ff @(posedge reloj) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_q == ST_CALC && cnt_q == '0) begin
            err_q <= ovf_q;
        end else if (state_q == ST_DONE && !go) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_div_secuencial.sv
// ============================================================================
// Module  : tb_mult_div_secuencial
// Brief   : Scoreboard bench for mult_div_secuencial with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_secuencial;

    localparam int N = 16;

    logic          reloj    = 1'b0;
    logic          reset    = 1'b1;
    logic [31:0]   ent_32   = '0;
    logic [15:0]   ent_16   = '0;
    logic          go       = 1'b0;
    logic          div_mult = 1'b0;
    logic [31:0]   sal_32;
    logic          done;
`ifdef MULT_DIV_ERR_EN
    logic          err;
`endif

    mult_div_secuencial #(.ANCHO(N)) dut (
        .reloj    (reloj),
        .reset    (reset),
        .ent_32   (ent_32),
        .ent_16   (ent_16),
        .go       (go),
        .div_mult (div_mult),
        .sal_32   (sal_32),
`ifdef MULT_DIV_ERR_EN
        .err      (err),
`endif
        .done     (done)
    );

    always #5 reloj = ~reloj;

    typedef struct {
        logic [31:0] sal;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic done_prev = 1'b0;

    always @(posedge reloj) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops an expectation on each rising edge of done.
    always @(negedge reloj) begin
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 with empty scoreboard, required none");
            end else begin
                mon_e = sbq.pop_front();
                chk("result", sal_32, mon_e.sal);
                chk("latency", cyc, mon_e.cyc);
`ifdef MULT_DIV_ERR_EN
                chk("err", {31'd0, err}, {31'd0, mon_e.err});
`endif
            end
        end
        done_prev = done;
    end

    task automatic do_op(input logic [31:0] a, input logic [15:0] b, input logic dv,
                         input logic [31:0] exp_sal, input logic exp_err, input int hold);
        int k;
        @(negedge reloj);
        ent_32   = a;
        ent_16   = b;
        div_mult = dv;
        go       = 1'b1;
        sbq.push_back('{exp_sal, exp_err, cyc + 1 + N});
        @(posedge reloj);
        #1;
        // Operands must be latched: scramble them while the op runs.
        ent_32   = 32'hDEAD_BEEF;
        ent_16   = 16'hC0DE;
        div_mult = ~dv;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge reloj);
            k++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got done=%b after %0d cycles, required 1", done, k);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge reloj);
            chk("done_hold", {31'd0, done}, 32'd1);
            chk("sal_hold", sal_32, exp_sal);
        end
        go = 1'b0;
        @(negedge reloj);
        chk("done_clear", {31'd0, done}, 32'd0);
`ifdef MULT_DIV_ERR_EN
        chk("err_clear", {31'd0, err}, 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge reloj);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sal", sal_32, 32'd0);
`ifdef MULT_DIV_ERR_EN
        chk("reset_err", {31'd0, err}, 32'd0);
`endif
        reset = 1'b0;

        do_op(32'h0000_1234, 16'h0056, 1'b0, 32'h0006_1D78, 1'b0, 0);
        do_op(32'hABCD_FFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0, 0);
        do_op(32'h0001_86A0, 16'h0007, 1'b1, 32'h0005_37CD, 1'b0, 0);
        do_op(32'h1234_5678, 16'h0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
        do_op(32'h0010_0000, 16'h0010, 1'b1, 32'hFFFF_FFFF, 1'b1, 5);
        do_op(32'h0000_FFFF, 16'h0001, 1'b1, 32'h0000_FFFF, 1'b0, 0);
        do_op(32'h000F_FFFF, 16'h0010, 1'b1, 32'h000F_FFFF, 1'b0, 0);
        do_op(32'h000F_0000, 16'h0010, 1'b1, 32'h0000_F000, 1'b0, 0);
        do_op(32'h0000_8000, 16'h0002, 1'b0, 32'h0001_0000, 1'b0, 0);
        do_op(32'h0000_0000, 16'hFFFF, 1'b0, 32'h0000_0000, 1'b0, 0);

        // Reset in the middle of a divide: nothing is queued for it.
        @(negedge reloj);
        ent_32   = 32'h0001_86A0;
        ent_16   = 16'h0007;
        div_mult = 1'b1;
        go       = 1'b1;
        @(posedge reloj);
        repeat (8) @(posedge reloj);
        @(negedge reloj);
        reset = 1'b1;
        go    = 1'b0;
        @(negedge reloj);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_sal", sal_32, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge reloj);
        chk("midreset_idle", {31'd0, done}, 32'd0);

        do_op(32'h0000_0003, 16'h0005, 1'b0, 32'h0000_000F, 1'b0, 0);

        repeat (3) @(negedge reloj);
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
